mdl_serial_sched: RTL and testbench
===================================

# mdl_serial_sched

Scheduler for the shared serial arithmetic window of the bubble memory controller. It owns the 20-phase timing rotator (active-low one-hot `ROT20_n`), clocked on the 2 MHz enable. Each frame it grants the phase 10..19 serial shift window to at most one of three serial-register requesters: cycle counter, page counter and address comparator. It replaces the per-block set/reset shift flags with one arbitrated shift strobe, carry-clear and completion pulse per requester.

## Interface
Parameters:
- `WIN_START`, 10: first phase of the serial shift window; the window always ends at phase 19, so the width is 20-`WIN_START`.
- `NREQ`, 3: number of requesters; fixed at 3 for this design, and any other value is unsupported.

Ports:
- `i_MCLK`  in  1  master clock; the only clock.
- `i_RST_n`  in  1  reset; synchronous, active-low.
- `i_CLK2M_PCEN_n`  in  1  2 MHz clock enable, active-low; all state advances only on MCLK edges where it is low.
- `i_SCHED_EN`  in  1  when high, new grants are allowed; when low, no new grants are issued and a frame already granted runs to completion.
- `i_REQ`  in  3  level requests; bit0 = cycle counter, bit1 = page counter, bit2 = address comparator.
- `o_ROT20_n`  out  20  active-low one-hot phase; bit p is low during phase p.
- `o_GRANT_VLD`  out  1  a grant is held for the current frame.
- `o_GRANT`  out  2  index of the granted requester; only meaningful when `o_GRANT_VLD` is high.
- `o_SHIFT`  out  3  per-requester shift strobe; high during phases `WIN_START`..19 of that requester's granted frame.
- `o_CARRY_CLR`  out  3  per-requester strobe, high during phase `WIN_START` of the granted frame (LSB cycle; the requester forces its carry-in to 0).
- `o_DONE`  out  3  per-requester strobe, high during phase 19 of the granted frame.

## Operation
- Phase register: 5-bit `phase`, range 0..19.
  - On each enable edge: 19 wraps to 0, otherwise `phase` increments by 1.
  - `o_ROT20_n` = ~(1 << `phase`), decoded combinationally.
  - Values 20..31 are illegal. If ever reached, the next enable edge forces `phase` to 0.
- Arbiter state:
  - `gvld` (1 bit), `gidx` (2 bits).
  - Round-robin pointer `rr` (2 bits, range 0..2).
- Grant decision happens only on the enable edge where `phase`==19, i.e. the 19→0 wrap:
  - If `i_SCHED_EN` is high and `i_REQ` is nonzero: search starts at `rr` and proceeds `rr`, `rr`+1, `rr`+2 (mod 3). The first set request is taken: `gvld`←1, `gidx`←k, `rr`←(k+1) mod 3.
  - Otherwise: `gvld`←0; `rr` is unchanged.
  - The grant is held for the full frame, phases 0..19. It is never changed mid-frame.
- Strobe outputs, combinational from `phase`, `gvld`, `gidx`:
  - `o_SHIFT[k]` = `gvld` & (`gidx`==k) & (`phase`≥`WIN_START`).
  - `o_CARRY_CLR[k]` = `gvld` & (`gidx`==k) & (`phase`==`WIN_START`).
  - `o_DONE[k]` = `gvld` & (`gidx`==k) & (`phase`==19).
- Requester contract:
  - Shift and carry-update on each enable edge while `o_SHIFT[k]` is high.
  - Drop `i_REQ[k]` no later than the edge that samples `o_DONE[k]`, unless it wants back-to-back service.
- If a request drops mid-frame, the grant is not aborted. The window completes and `o_SHIFT` and `o_DONE` still assert.
- A request present at wrap with `i_SCHED_EN` low is ignored for that frame.
- `o_GRANT_VLD` = `gvld`; `o_GRANT` = `gidx`.

## Timing
- Frame length: 20 enables. The window is phases `WIN_START`..19, 10 enables at default.
- Grant latency:
  - A request asserted by phase 19 of frame N (sampled at the wrap edge) receives its window in frame N+1.
  - Minimum 1 enable to grant-valid; `WIN_START`+1 enables to the first shift.
- Back-to-back: a requester that holds `i_REQ` while the other requests are low is granted every frame with no gap.
- Reset:
  - Applies on any MCLK edge with `i_RST_n` low, regardless of `i_CLK2M_PCEN_n`.
  - State after reset: `phase`=0, `gvld`=0, `gidx`=0, `rr`=0.
  - Outputs after reset: `o_ROT20_n`=20'hFFFFE, `o_GRANT_VLD`=0, `o_GRANT`=0, and `o_SHIFT`/`o_CARRY_CLR`/`o_DONE`=0.
  - A reset mid-window truncates the window immediately; no `o_DONE` is issued.
- Between enables, every output holds its value.

## Structure
- Shared package `sched_pkg`:
  - Constants: `ROT_LEN`=20, `PH_WIN_END`=19.
  - Requester indices: `REQ_CYC`=0, `REQ_PAGE`=1, `REQ_CMP`=2.
  - Typedef `phase_t` = 5-bit phase.
- Sub-module `mdl_rot20gen` (one instance) contains:
  - the phase counter, illegal-state recovery and one-hot active-low decode;
  - an output of `phase` for the arbiter.
- The arbiter and strobe decode live in `mdl_serial_sched` itself.

## Test plan
- Reset, then 40 enables with `i_REQ`=0:
  - `o_ROT20_n` steps 20'hFFFFE, 20'hFFFFD, … 20'h7FFFF, then wraps.
  - `o_GRANT_VLD` stays 0 throughout.
- `i_REQ`=3'b111 held for 4 frames:
  - Grants are 0, 1, 2, 0.
  - Each frame shows 10 `o_SHIFT` enables for the granted index, `o_CARRY_CLR` at phase 10 and `o_DONE` at phase 19.
- `i_REQ[1]` rises at phase 5 and drops at phase 3 of the next frame:
  - The grant for index 1 still covers that full frame, with shift phases 10..19 and `o_DONE` asserted.
- `i_SCHED_EN` low at the wrap with `i_REQ`=3'b001 → no grant that frame.
  - `i_SCHED_EN` is raised before the next wrap → grant to 0 in the following frame.
  - `rr` is unchanged across the ungranted frame.
- `i_RST_n` pulsed low at phase 14 of a granted frame:
  - On the next edge, `o_SHIFT`=0, `o_GRANT_VLD`=0 and `o_ROT20_n`=20'hFFFFE.
  - No `o_DONE` pulse appears for the truncated window.
- `i_CLK2M_PCEN_n` held high for 7 MCLKs mid-window → all outputs frozen; the sequence resumes with no skipped phase.

Source files
------------

// File: rtl/sched_pkg.sv
// sched_pkg: shared constants, requester indices and phase type for the
// serial arithmetic window scheduler.
`default_nettype none

package sched_pkg;

  localparam int ROT_LEN    = 20;
  localparam int PH_WIN_END = 19;

  localparam int REQ_CYC  = 0;
  localparam int REQ_PAGE = 1;
  localparam int REQ_CMP  = 2;

  typedef logic [4:0] phase_t;

  // Round-robin successor over the three requesters (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdl_rot20gen.sv
// mdl_rot20gen: 20-phase timing rotator advanced on the 2 MHz enable, with
// recovery from illegal phase values and an active-low one-hot decode.
`default_nettype none

module mdl_rot20gen
  import sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en_n,
  output phase_t              phase,
  output logic [ROT_LEN-1:0]  rot20_n
);

  // The >= compare also sends any illegal value (20..31) back to phase 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (!clk_en_n) begin
      if (phase >= phase_t'(PH_WIN_END))
        phase <= '0;
      else
        phase <= phase + phase_t'(1);
    end
  end

  always_comb begin
    rot20_n = '1;
    for (int p = 0; p < ROT_LEN; p++)
      rot20_n[p] = (phase != phase_t'(p));
  end

endmodule

`default_nettype wire

// File: rtl/mdl_serial_sched.sv
// mdl_serial_sched: per-frame round-robin grant of the shared serial shift
// window (phases WIN_START..19) to the cycle counter, page counter or comparator.
`default_nettype none

module mdl_serial_sched
  import sched_pkg::*;
#(
  parameter int WIN_START = 10,
  parameter int NREQ      = 3
)(
  input  logic                i_MCLK,
  input  logic                i_RST_n,
  input  logic                i_CLK2M_PCEN_n,
  input  logic                i_SCHED_EN,
  input  logic [NREQ-1:0]     i_REQ,
  output logic [ROT_LEN-1:0]  o_ROT20_n,
  output logic                o_GRANT_VLD,
  output logic [1:0]          o_GRANT,
  output logic [NREQ-1:0]     o_SHIFT,
  output logic [NREQ-1:0]     o_CARRY_CLR,
  output logic [NREQ-1:0]     o_DONE
);

  phase_t      phase;
  logic        gvld;
  logic [1:0]  gidx;
  logic [1:0]  rr;
  logic        found;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;

  mdl_rot20gen u_rot (
    .clk      (i_MCLK),
    .rst_n    (i_RST_n),
    .clk_en_n (i_CLK2M_PCEN_n),
    .phase    (phase),
    .rot20_n  (o_ROT20_n)
  );

  // Search rr, rr+1, rr+2 (mod 3); the first set request wins.
  always_comb begin
    found    = 1'b0;
    pick_idx = rr;
    cand     = rr;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && i_REQ[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
      cand = inc_mod3(cand);
    end
  end

  // The grant only changes at the 19 -> 0 wrap, so it spans a whole frame.
  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) begin
      gvld <= 1'b0;
      gidx <= 2'd0;
      rr   <= 2'd0;
    end else if (!i_CLK2M_PCEN_n && phase == phase_t'(PH_WIN_END)) begin
      if (i_SCHED_EN && found) begin
        gvld <= 1'b1;
        gidx <= pick_idx;
        rr   <= inc_mod3(pick_idx);
      end else begin
        gvld <= 1'b0;
      end
    end
  end

  always_comb begin
    o_SHIFT     = '0;
    o_CARRY_CLR = '0;
    o_DONE      = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gvld && gidx == 2'(k)) begin
        o_SHIFT[k]     = (phase >= phase_t'(WIN_START));
        o_CARRY_CLR[k] = (phase == phase_t'(WIN_START));
        o_DONE[k]      = (phase == phase_t'(PH_WIN_END));
      end
    end
  end

  assign o_GRANT_VLD = gvld;
  assign o_GRANT     = gidx;

endmodule

`default_nettype wire

// File: tb/tb_mdl_serial_sched.sv
// tb_mdl_serial_sched: directed test-plan sequences plus random traffic,
// scored against a frame-level reference model through an expectation queue.
`default_nettype none

module tb_mdl_serial_sched;

  localparam int WIN = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcen_n;
  logic        sched_en;
  logic [2:0]  req;
  logic [19:0] rot20_n;
  logic        grant_vld;
  logic [1:0]  grant;
  logic [2:0]  shift, carry_clr, done;

  typedef struct packed {
    logic [19:0] rot;
    logic        vld;
    logic [1:0]  idx;
    logic [2:0]  sh;
    logic [2:0]  cc;
    logic [2:0]  dn;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state: phase number, held grant, round-robin pointer.
  int m_phase = 0;
  int m_gvld  = 0;
  int m_gidx  = 0;
  int m_rr    = 0;

  mdl_serial_sched #(.WIN_START(WIN), .NREQ(3)) dut (
    .i_MCLK         (clk),
    .i_RST_n        (rst_n),
    .i_CLK2M_PCEN_n (pcen_n),
    .i_SCHED_EN     (sched_en),
    .i_REQ          (req),
    .o_ROT20_n      (rot20_n),
    .o_GRANT_VLD    (grant_vld),
    .o_GRANT        (grant),
    .o_SHIFT        (shift),
    .o_CARRY_CLR    (carry_clr),
    .o_DONE         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // Advance the model by one MCLK edge using the currently driven inputs.
  task automatic model_edge();
    if (!rst_n) begin
      m_phase = 0; m_gvld = 0; m_gidx = 0; m_rr = 0;
    end else if (!pcen_n) begin
      if (m_phase == 19) begin
        m_gvld = 0;
        if (sched_en) begin
          for (int j = 0; j < 3; j++) begin
            int k;
            k = (m_rr + j) % 3;
            if (m_gvld == 0 && req[k]) begin
              m_gvld = 1; m_gidx = k; m_rr = (k + 1) % 3;
            end
          end
        end
      end
      m_phase = (m_phase + 1) % 20;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.rot = ~(20'd1 << m_phase);
    e.vld = (m_gvld != 0);
    e.idx = 2'(m_gidx);
    e.sh  = (m_gvld != 0 && m_phase >= WIN) ? 3'(1 << m_gidx) : 3'd0;
    e.cc  = (m_gvld != 0 && m_phase == WIN) ? 3'(1 << m_gidx) : 3'd0;
    e.dn  = (m_gvld != 0 && m_phase == 19)  ? 3'(1 << m_gidx) : 3'd0;
    return e;
  endfunction

  task automatic step();
    model_edge();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_phase(input int p);
    pcen_n = 1'b0;
    for (int n = 0; n < 40 && m_phase != p; n++) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, want);
    end
  endtask

  // Monitor: one expectation per MCLK edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rot20_n",   32'(rot20_n),   32'(e.rot));
      chk("grant_vld", 32'(grant_vld), 32'(e.vld));
      chk("grant",     32'(grant),     32'(e.idx));
      chk("shift",     32'(shift),     32'(e.sh));
      chk("carry_clr", 32'(carry_clr), 32'(e.cc));
      chk("done",      32'(done),      32'(e.dn));
      cyc++;
    end
  end

  initial begin
    rst_n = 1'b0; pcen_n = 1'b1; sched_en = 1'b1; req = 3'b000;
    step(); step();
    rst_n = 1'b1;

    // Idle rotation: two full frames with no requests.
    pcen_n = 1'b0;
    repeat (40) step();

    // All three requesting: grants rotate 0, 1, 2, 0.
    run_to_phase(15);
    req = 3'b111;
    repeat (85) step();
    req = 3'b000;
    repeat (20) step();

    // Request 1 rises at phase 5 and drops at phase 3 of the granted frame.
    run_to_phase(5);
    req = 3'b010;
    run_to_phase(0);
    run_to_phase(3);
    req = 3'b000;
    repeat (40) step();

    // Scheduler disabled at the wrap, re-enabled before the next one.
    run_to_phase(12);
    sched_en = 1'b0;
    req = 3'b001;
    run_to_phase(0);
    run_to_phase(8);
    sched_en = 1'b1;
    repeat (30) step();

    // Reset during phase 14 of a granted frame truncates the window.
    run_to_phase(14);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 3'b000;
    repeat (25) step();

    // Enable held off for 7 MCLKs in the middle of a window.
    req = 3'b100;
    run_to_phase(0);
    run_to_phase(12);
    pcen_n = 1'b1;
    repeat (7) step();
    pcen_n = 1'b0;
    req = 3'b000;
    repeat (30) step();

    // Random traffic with gapped enables and rare resets.
    for (int n = 0; n < 1500; n++) begin
      pcen_n   = ($urandom_range(0, 3) == 0);
      sched_en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
      rst_n    = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
